// File: rtl/life_pkg.sv
// Shared types and constants for the cellular automaton engine.
// Rule masks are indexed by live-neighbour count 0..8.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  typedef logic [3:0] ncnt_t;

  localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
  localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-state evaluator for one grid row.
// Off-grid rows are handed in as zero by the caller when not wrapping.
module life_row_eval
  import life_pkg::*;
#(
  parameter int NUM_COLS = 8,
  parameter int WRAP     = 1
) (
  input  logic [NUM_COLS-1:0] above_i,
  input  logic [NUM_COLS-1:0] cur_i,
  input  logic [NUM_COLS-1:0] below_i,
  input  logic [8:0]          birth_i,
  input  logic [8:0]          survive_i,
  output logic [NUM_COLS-1:0] row_o
);

  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  ncnt_t cnt;
  int    cc;

  // Count the eight neighbours of each column and apply the rule masks
  always_comb begin
    row_o = '0;
    cnt   = '0;
    cc    = 0;
    for (int c = 0; c < NUM_COLS; c++) begin
      cnt = '0;
      for (int d = -1; d <= 1; d++) begin
        cc = c + d;
        if (WRAP != 0) cc = (cc + NUM_COLS) % NUM_COLS;
        if (cc >= 0 && cc < NUM_COLS) begin
          cnt = cnt + ncnt_t'(above_i[CW'(cc)]);
          cnt = cnt + ncnt_t'(below_i[CW'(cc)]);
          if (d != 0) cnt = cnt + ncnt_t'(cur_i[CW'(cc)]);
        end
      end
      row_o[CW'(c)] = cur_i[CW'(c)] ? survive_i[cnt] : birth_i[cnt];
    end
  end

endmodule

// File: rtl/life_engine.sv
// Row-serial Game-of-Life style engine: one row per cycle into a
// shadow buffer, then a single-cycle commit to the visible grid.
module life_engine
  import life_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8,
  parameter int WRAP     = 1,
  parameter int GEN_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [NUM_ROWS*NUM_COLS-1:0] seed_bits,
  input  logic                         step,
  input  logic [8:0]                   rule_birth,
  input  logic [8:0]                   rule_survive,
  output logic [NUM_ROWS*NUM_COLS-1:0] cur_bits,
  output logic                         busy,
  output logic                         done,
  output logic [GEN_W-1:0]             gen_count,
  output logic                         extinct,
  output logic                         stable
);

  localparam int N  = NUM_ROWS * NUM_COLS;
  localparam int RW = $clog2(NUM_ROWS);

  state_e               state_q, state_d;
  logic [RW-1:0]        row_q;
  logic [N-1:0]         cur_q, next_q;
  logic [GEN_W-1:0]     gen_q;
  logic [8:0]           birth_q, surv_q;
  logic                 done_q, ext_q, stab_q;
  logic                 row_last;
  logic [NUM_COLS-1:0]  above, middle, below, new_row;
  int                   r, ra, rb;

  assign row_last = (row_q == RW'(NUM_ROWS - 1));

  // Select the current row and its vertical neighbours from the grid
  always_comb begin
    r      = int'(row_q);
    ra     = (r == 0) ? NUM_ROWS - 1 : r - 1;
    rb     = (r == NUM_ROWS - 1) ? 0 : r + 1;
    middle = cur_q[r*NUM_COLS +: NUM_COLS];
    above  = cur_q[ra*NUM_COLS +: NUM_COLS];
    below  = cur_q[rb*NUM_COLS +: NUM_COLS];
    if (WRAP == 0 && r == 0) above = '0;
    if (WRAP == 0 && r == NUM_ROWS - 1) below = '0;
  end

  life_row_eval #(
    .NUM_COLS (NUM_COLS),
    .WRAP     (WRAP)
  ) u_row (
    .above_i   (above),
    .cur_i     (middle),
    .below_i   (below),
    .birth_i   (birth_q),
    .survive_i (surv_q),
    .row_o     (new_row)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!load && step) state_d = COMPUTE;
      COMPUTE: if (row_last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      COMPUTE: busy = 1'b1;
      COMMIT:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Grid, buffer, status and counter datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      gen_q   <= '0;
      birth_q <= '0;
      surv_q  <= '0;
      done_q  <= 1'b0;
      ext_q   <= 1'b1;
      stab_q  <= 1'b0;
    end else begin
      done_q <= (state_q == COMMIT);
      unique case (state_q)
        IDLE: begin
          if (load) begin
            cur_q  <= seed_bits;
            gen_q  <= '0;
            ext_q  <= (seed_bits == '0);
            stab_q <= 1'b0;
          end else if (step) begin
            birth_q <= rule_birth;
            surv_q  <= rule_survive;
            row_q   <= '0;
          end
        end
        COMPUTE: begin
          next_q[row_q*NUM_COLS +: NUM_COLS] <= new_row;
          if (!row_last) row_q <= row_q + 1'b1;
        end
        COMMIT: begin
          cur_q  <= next_q;
          stab_q <= (next_q == cur_q);
          ext_q  <= (next_q == '0);
          if (gen_q != '1) gen_q <= gen_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cur_bits  = cur_q;
  assign done      = done_q;
  assign gen_count = gen_q;
  assign extinct   = ext_q;
  assign stable    = stab_q;

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench: two 8x8 engines (toroidal and bounded) share stimulus
// and are checked against a whole-grid reference model.
module tb_life_engine;

  typedef struct {
    logic [63:0] cur;
    logic [15:0] gen;
    logic        ext;
    logic        stab;
    int          cyc;
  } exp_t;

  localparam logic [8:0] CB = 9'h008;
  localparam logic [8:0] CS = 9'h00C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        step = 1'b0;
  logic [63:0] seed_bits = '0;
  logic [8:0]  rule_birth = '0;
  logic [8:0]  rule_survive = '0;

  logic [63:0] cur1, cur0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] gen1, gen0;
  logic        ext1, ext0, stab1, stab0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] mcur[2];
  logic [15:0] mgen[2];

  life_engine #(.NUM_ROWS(8), .NUM_COLS(8), .WRAP(1), .GEN_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .load(load), .seed_bits(seed_bits),
    .step(step), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .cur_bits(cur1), .busy(busy1), .done(done1), .gen_count(gen1),
    .extinct(ext1), .stable(stab1)
  );

  life_engine #(.NUM_ROWS(8), .NUM_COLS(8), .WRAP(0), .GEN_W(16)) u_w0 (
    .clk(clk), .rst_n(rst_n), .load(load), .seed_bits(seed_bits),
    .step(step), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .cur_bits(cur0), .busy(busy0), .done(done0), .gen_count(gen0),
    .extinct(ext0), .stable(stab0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference next generation computed over the whole grid
  function automatic logic [63:0] life_ref(input logic [63:0] g,
      input int wrap, input logic [8:0] b, input logic [8:0] s);
    logic [63:0] res;
    int n, rr, cc;
    res = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy == 0 && dx == 0) continue;
            rr = y + dy;
            cc = x + dx;
            if (wrap != 0) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              continue;
            end
            n += int'(g[rr*8+cc]);
          end
        end
        res[y*8+x] = g[y*8+x] ? s[n] : b[n];
      end
    end
    return res;
  endfunction

  task automatic chk_done(input int w, input logic [63:0] c,
      input logic [15:0] g, input logic e, input logic s, input logic b);
    exp_t x;
    string p;
    p = (w == 1) ? "w1" : "w0";
    if ((w == 1 && q1.size() == 0) || (w == 0 && q0.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_done: got done=1 expected none", p);
      return;
    end
    x = (w == 1) ? q1.pop_front() : q0.pop_front();
    chk({p, "_cur"}, c, x.cur);
    chk({p, "_gen"}, 64'(g), 64'(x.gen));
    chk({p, "_extinct"}, 64'(e), 64'(x.ext));
    chk({p, "_stable"}, 64'(s), 64'(x.stab));
    chk({p, "_busy_at_done"}, 64'(b), 64'd0);
    chk({p, "_latency"}, 64'(cyc), 64'(x.cyc));
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n) begin
      if (done1) chk_done(1, cur1, gen1, ext1, stab1, busy1);
      if (done0) chk_done(0, cur0, gen0, ext0, stab0, busy0);
    end
  end

  task automatic do_load(input logic [63:0] s);
    @(negedge clk);
    load = 1'b1;
    seed_bits = s;
    @(posedge clk);
    #1 load = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mcur[w] = s;
      mgen[w] = '0;
    end
    chk("load_cur", cur1, s);
    chk("load_gen", 64'(gen0), 64'd0);
    chk("load_extinct", 64'(ext1), 64'(s == '0));
    chk("load_stable", 64'(stab0), 64'd0);
  endtask

  task automatic start_step(input logic [8:0] b, input logic [8:0] s);
    exp_t x;
    int t;
    @(negedge clk);
    rule_birth = b;
    rule_survive = s;
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    t = cyc;
    rule_birth = 9'($urandom);
    rule_survive = 9'($urandom);
    for (int w = 0; w < 2; w++) begin
      x.cur  = life_ref(mcur[w], w, b, s);
      x.gen  = (mgen[w] == 16'hFFFF) ? mgen[w] : mgen[w] + 16'd1;
      x.ext  = (x.cur == '0);
      x.stab = (x.cur == mcur[w]);
      x.cyc  = t + 9;
      mcur[w] = x.cur;
      mgen[w] = x.gen;
      if (w == 1) q1.push_back(x);
      else        q0.push_back(x);
    end
    chk("busy_after_step", 64'({busy1, busy0}), 64'd3);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++)
      @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got pending=%0d expected 0",
               q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic do_step(input logic [8:0] b, input logic [8:0] s);
    start_step(b, s);
    wait_done();
  endtask

  logic [63:0] rs;
  logic [8:0]  rb, rsv;

  initial begin
    #12;
    n_tests++;
    if ({cur1, gen1, busy1, done1, stab1, ext1} !== {64'd0, 16'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected cur=0 gen=0 ext=1", cur1);
    end
    chk("reset_ext0", 64'(ext0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mcur[0] = '0; mcur[1] = '0;
    mgen[0] = '0; mgen[1] = '0;

    // Blinker
    do_load((64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
    do_step(CB, CS);
    chk("blinker", cur1, (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35));

    // Edge behaviour
    do_load(64'h7);
    do_step(CB, CS);
    chk("edge_w0", cur0, 64'h202);
    chk("edge_w1", cur1, (64'd1 << 1) | (64'd1 << 9) | (64'd1 << 57));

    // Block still life
    do_load(64'h303);
    do_step(CB, CS);
    chk("block_cur", cur0, 64'h303);
    chk("block_stable", 64'({stab0, ext0}), 64'd2);

    // Lone cell dies, then stays dead
    do_load(64'd1 << 27);
    do_step(CB, CS);
    chk("single_extinct", 64'({cur1 == '0, ext1}), 64'd3);
    do_step(CB, CS);
    chk("single_gen2", 64'(gen1), 64'd2);
    chk("single_stable", 64'(stab1), 64'd1);

    // load/step while busy are ignored
    do_load((64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
    start_step(CB, CS);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load = 1'b1;
      step = 1'b1;
      seed_bits = '1;
    end
    @(negedge clk);
    load = 1'b0;
    step = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    chk("ignore_busy_cur", cur1, (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35));

    // Randomised seeds and rules
    for (int k = 0; k < 25; k++) begin
      rs = {$urandom, $urandom};
      if (k % 2 == 1) rs = rs & {$urandom, $urandom};
      do_load(rs);
      for (int j = 0; j < 1 + (k % 3); j++) begin
        rb  = (k % 3 == 0) ? 9'($urandom) : CB;
        rsv = (k % 3 == 0) ? 9'($urandom) : CS;
        do_step(rb, rsv);
      end
    end

    // Reset during COMPUTE aborts the generation
    do_load((64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
    start_step(CB, CS);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    mcur[0] = '0; mcur[1] = '0;
    mgen[0] = '0; mgen[1] = '0;
    chk("rst_cur", cur1 | cur0, 64'd0);
    chk("rst_flags", 64'({busy1, done1, stab1, ext1, busy0, ext0}), 64'b000101);
    chk("rst_gen", 64'(gen1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_after_gen", 64'(gen0), 64'd0);
    chk("rst_after_cur", cur1, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
